// File: rtl/cv32e40x_div.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU.
// 32 steps per general op; divide-by-zero and overflow finish in one cycle.
module cv32e40x_div (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_i,
  input  logic [1:0]  operator_i,
  input  logic [31:0] op_a_i,
  input  logic [31:0] op_b_i,
  output logic [31:0] result_o,
  output logic        ready_o,
  output logic        valid_o,
  input  logic        ready_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [32:0] rem_q, rem_d;
  logic [31:0] quot_q, quot_d;
  logic [31:0] dvs_q, dvs_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [1:0]  op_q, op_d;
  logic        negq_q, negq_d;
  logic        negr_q, negr_d;

  logic        sgn;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [33:0] t;

  // Next-state, datapath step and operand capture
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    quot_d  = quot_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    sgn     = ~operator_i[0];
    abs_a   = (sgn && op_a_i[31]) ? (32'd0 - op_a_i) : op_a_i;
    abs_b   = (sgn && op_b_i[31]) ? (32'd0 - op_b_i) : op_b_i;
    t       = {rem_q, quot_q[31]} - {2'b00, dvs_q};
    if (!valid_i) begin
      state_d = IDLE;
      rem_d   = '0;
      quot_d  = '0;
      dvs_d   = '0;
      cnt_d   = '0;
      op_d    = '0;
      negq_d  = 1'b0;
      negr_d  = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          op_d  = operator_i;
          cnt_d = '0;
          dvs_d = abs_b;
          if (op_b_i == 32'd0) begin
            state_d = DONE;
            quot_d  = 32'hFFFF_FFFF;
            rem_d   = {1'b0, op_a_i};
            negq_d  = 1'b0;
            negr_d  = 1'b0;
          end else if (sgn && op_a_i == 32'h8000_0000
                       && op_b_i == 32'hFFFF_FFFF) begin
            state_d = DONE;
            quot_d  = 32'h8000_0000;
            rem_d   = '0;
            negq_d  = 1'b0;
            negr_d  = 1'b0;
          end else begin
            state_d = CALC;
            quot_d  = abs_a;
            rem_d   = '0;
            negq_d  = sgn & (op_a_i[31] ^ op_b_i[31]);
            negr_d  = sgn & op_a_i[31];
          end
        end
        CALC: begin
          if (!t[33]) begin
            rem_d  = t[32:0];
            quot_d = {quot_q[30:0], 1'b1};
          end else begin
            rem_d  = {rem_q[31:0], quot_q[31]};
            quot_d = {quot_q[30:0], 1'b0};
          end
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd31) state_d = DONE;
        end
        DONE: begin
          if (ready_i) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Handshake outputs and sign-corrected result
  always_comb begin
    valid_o  = (state_q == DONE) && valid_i;
    ready_o  = !valid_i || ((state_q == DONE) && ready_i);
    result_o = '0;
    if (state_q == DONE) begin
      if (op_q[1])
        result_o = negr_q ? (32'd0 - rem_q[31:0]) : rem_q[31:0];
      else
        result_o = negq_q ? (32'd0 - quot_q) : quot_q;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rem_q   <= '0;
      quot_q  <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      op_q    <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      quot_q  <= quot_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
    end
  end

endmodule
